effective_addr_unit: RTL and testbench

EFFECTIVE_ADDR_UNIT -- requirements
Module: effective_addr_unit

---
 rtl/effective_addr_unit.sv | 145 ++++++++++++++
 tb/tb_effective_addr_unit.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/effective_addr_unit.sv
// Effective address unit: base + sext(offset) computed one nibble per cycle
// through a 4-bit carry-lookahead slice, followed by alignment checking.

// One 4-bit carry-lookahead group.
module effective_addr_cla4 (
  input  logic [3:0] a,
  input  logic [3:0] b,
  input  logic       cin,
  output logic [3:0] sum,
  output logic       cout
);
  logic [3:0] p, g;
  logic       c1, c2, c3;

  assign p = a ^ b;
  assign g = a & b;

  assign c1   = g[0] | (p[0] & cin);
  assign c2   = g[1] | (p[1] & g[0]) | (p[1] & p[0] & cin);
  assign c3   = g[2] | (p[2] & g[1]) | (p[2] & p[1] & g[0])
              | (p[2] & p[1] & p[0] & cin);
  assign cout = g[3] | (p[3] & g[2]) | (p[3] & p[2] & g[1])
              | (p[3] & p[2] & p[1] & g[0]) | (p[3] & p[2] & p[1] & p[0] & cin);

  assign sum = p ^ {c3, c2, c1, cin};
endmodule

module effective_addr_unit #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [ADDR_W-1:0] base,
  input  logic [15:0]       offset,
  input  logic [1:0]        size,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ADDR_W-1:0] addr,
  output logic [ADDR_W-1:0] aligned_addr,
  output logic              misaligned,
  output logic              carry_out
);
  localparam int NIBS  = ADDR_W / 4;
  localparam int NIB_W = (NIBS > 1) ? $clog2(NIBS) : 1;

  typedef enum logic [1:0] {IDLE = 2'd0, ADD = 2'd1, DONE = 2'd2} state_t;

  state_t            state;
  logic [ADDR_W-1:0] a_reg, b_reg, sum_reg, sum_next, aligned_reg, aligned_next;
  logic [ADDR_W-1:0] off_ext;
  logic [1:0]        size_reg;
  logic [NIB_W-1:0]  nib;
  logic              carry, co_reg, mis_reg, mis_next, last;
  logic [3:0]        nib_a, nib_b, nib_s;
  logic              nib_c;

  // Signed cast sign-extends (or truncates) the immediate to the address width.
  assign off_ext = ADDR_W'($signed(offset));

  assign nib_a = a_reg[{nib, 2'b00} +: 4];
  assign nib_b = b_reg[{nib, 2'b00} +: 4];
  assign last  = (nib == NIB_W'(NIBS - 1));

  effective_addr_cla4 u_cla (
    .a    (nib_a),
    .b    (nib_b),
    .cin  (carry),
    .sum  (nib_s),
    .cout (nib_c)
  );

  // Splice the freshly computed nibble into the running sum, and derive the
  // alignment results from that so the last group sees the completed address.
  always_comb begin
    sum_next = sum_reg;
    sum_next[{nib, 2'b00} +: 4] = nib_s;
    aligned_next = {sum_next[ADDR_W-1:2], sum_next[1] & ~size_reg[1],
                    sum_next[0] & (size_reg == 2'b00)};
    case (size_reg)
      2'b00:   mis_next = 1'b0;
      2'b01:   mis_next = sum_next[0];
      2'b10:   mis_next = |sum_next[1:0];
      default: mis_next = 1'b1;
    endcase
  end

  // Control FSM and datapath registers; reset wins over any handshake.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      nib         <= '0;
      carry       <= 1'b0;
      a_reg       <= '0;
      b_reg       <= '0;
      size_reg    <= 2'b00;
      sum_reg     <= '0;
      aligned_reg <= '0;
      mis_reg     <= 1'b0;
      co_reg      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg       <= base;
            b_reg       <= off_ext;
            size_reg    <= size;
            carry       <= 1'b0;
            nib         <= '0;
            sum_reg     <= '0;
            aligned_reg <= '0;
            mis_reg     <= 1'b0;
            co_reg      <= 1'b0;
            state       <= ADD;
          end
        end
        ADD: begin
          sum_reg <= sum_next;
          carry   <= nib_c;
          // Index returns to 0 after the top group so it never points past
          // the operand when the width is not a power-of-two nibble count.
          nib     <= last ? '0 : nib + 1'b1;
          if (last) begin
            co_reg      <= nib_c;
            mis_reg     <= mis_next;
            aligned_reg <= aligned_next;
            state       <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready     = (state == IDLE);
  assign out_valid    = (state == DONE);
  assign addr         = sum_reg;
  assign aligned_addr = aligned_reg;
  assign misaligned   = mis_reg;
  assign carry_out    = co_reg;
endmodule

// File: tb/tb_effective_addr_unit.sv
// Randomized scoreboard bench for effective_addr_unit (ADDR_W = 32).
module tb_effective_addr_unit;
  localparam int AW   = 32;
  localparam int NIBS = AW / 4;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] base;
  logic [15:0]   offset;
  logic [1:0]    size;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] addr, aligned_addr;
  logic          misaligned, carry_out;

  effective_addr_unit #(.ADDR_W(AW)) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .base         (base),
    .offset       (offset),
    .size         (size),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .addr         (addr),
    .aligned_addr (aligned_addr),
    .misaligned   (misaligned),
    .carry_out    (carry_out)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [AW-1:0] addr;
    logic [AW-1:0] al;
    logic          mis;
    logic          co;
    int            acc;
  } exp_t;

  exp_t q[$];
  int   vectors = 0;
  int   miscompares = 0;
  int   cyc = 0;
  bit   rdy_rand = 1'b1;
  bit   rdy_force = 1'b1;
  bit   prev_ov = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  // Consumer: random backpressure unless a test forces the level.
  always @(posedge clk) begin
    #1;
    out_ready = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_force;
  end

  // Reference: plain wide arithmetic plus the alignment rules.
  function automatic exp_t model(logic [AW-1:0] b, logic [15:0] o, logic [1:0] s);
    exp_t        m;
    logic [AW:0] full;
    full   = {1'b0, b} + {1'b0, {{(AW-16){o[15]}}, o}};
    m.addr = full[AW-1:0];
    m.co   = full[AW];
    m.acc  = 0;
    case (s)
      2'b00:   begin m.al = m.addr;           m.mis = 1'b0; end
      2'b01:   begin m.al = m.addr & ~32'h1;  m.mis = m.addr[0]; end
      2'b10:   begin m.al = m.addr & ~32'h3;  m.mis = (m.addr % 4) != 0; end
      default: begin m.al = m.addr & ~32'h3;  m.mis = 1'b1; end
    endcase
    return m;
  endfunction

  // Monitor: compares the head of the queue every cycle the result is shown,
  // which also covers stability while the consumer stalls.
  always @(negedge clk) begin
    if (!reset) begin
      if (out_valid) begin
        vectors++;
        if (in_ready) begin
          miscompares++;
          $display("FAIL in_ready_in_done: in_ready=%0b required 0", in_ready);
        end
        if (q.size() == 0) begin
          miscompares++;
          $display("FAIL unexpected_out_valid: out_valid=1 with nothing outstanding");
        end else begin
          exp_t e;
          e = q[0];
          if (!prev_ov) begin
            vectors++;
            if (cyc - e.acc != NIBS) begin
              miscompares++;
              $display("FAIL latency: %0d edges required %0d", cyc - e.acc, NIBS);
            end
          end
          if (addr !== e.addr || aligned_addr !== e.al || misaligned !== e.mis ||
              carry_out !== e.co) begin
            miscompares++;
            $display("FAIL result: addr=%h al=%h mis=%0b co=%0b required addr=%h al=%h mis=%0b co=%0b",
                     addr, aligned_addr, misaligned, carry_out, e.addr, e.al, e.mis, e.co);
          end
          if (out_ready) void'(q.pop_front());
        end
      end
      prev_ov = out_valid;
    end else begin
      prev_ov = 1'b0;
    end
  end

  task automatic check(string name, logic [63:0] got, logic [63:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %h required %h", name, got, want);
    end
  endtask

  task automatic issue(logic [AW-1:0] b, logic [15:0] o, logic [1:0] s);
    exp_t e;
    bit   ok;
    @(posedge clk); #1;
    in_valid = 1'b1; base = b; offset = o; size = s;
    ok = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (in_ready) begin ok = 1'b1; break; end
    end
    if (!ok) begin
      miscompares++;
      $display("FAIL accept_timeout: in_ready stayed 0 for 60 cycles");
    end else begin
      e = model(b, o, s);
      e.acc = cyc + 1;
      q.push_back(e);
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
    base = $urandom; offset = 16'($urandom); size = 2'($urandom);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && q.size() != 0; i++) @(negedge clk);
    vectors++;
    if (q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d results outstanding, required 0", q.size());
      q.delete();
    end
  endtask

  initial begin
    bit saw;
    reset = 1'b1; in_valid = 1'b0; base = '0; offset = '0; size = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_outputs", {addr, aligned_addr} | 64'({misaligned, carry_out}), 64'd0);

    // Directed corner vectors.
    issue(32'h0000_1000, 16'h0004, 2'b10);
    issue(32'hFFFF_FFFF, 16'h0001, 2'b00);
    issue(32'h0000_0010, 16'hFFFC, 2'b10);
    issue(32'h0000_0003, 16'h0000, 2'b01);
    issue(32'h0000_0003, 16'h0000, 2'b11);
    issue(32'h0000_0000, 16'hFFFF, 2'b00);
    issue(32'h7FFF_FFFF, 16'h7FFF, 2'b01);
    drain();

    // Consumer stall in DONE, then release.
    rdy_rand = 1'b0; rdy_force = 1'b0;
    issue(32'h1234_5671, 16'h8001, 2'b01);
    saw = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin saw = 1'b1; break; end
    end
    check("stall_out_valid_seen", 64'(saw), 64'd1);
    repeat (5) @(negedge clk);
    check("stall_in_ready", 64'(in_ready), 64'd0);
    check("stall_out_valid", 64'(out_valid), 64'd1);
    rdy_force = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("release_in_ready", 64'(in_ready), 64'd1);
    check("release_out_valid", 64'(out_valid), 64'd0);
    rdy_rand = 1'b1;
    issue(32'hDEAD_BEEF, 16'h0011, 2'b10);
    drain();

    // Reset during ADD after four groups.
    issue(32'hCAFE_F00D, 16'hFF00, 2'b10);
    repeat (4) @(posedge clk);
    #1 reset = 1'b1;
    q.delete();
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("midreset_in_ready", 64'(in_ready), 64'd1);
    check("midreset_out_valid", 64'(out_valid), 64'd0);
    check("midreset_outputs", {addr, aligned_addr} | 64'({misaligned, carry_out}), 64'd0);
    saw = 1'b0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (out_valid) saw = 1'b1;
    end
    check("midreset_no_out_valid", 64'(saw), 64'd0);
    issue(32'h0000_1000, 16'h0004, 2'b10);
    drain();

    // Randomized traffic with occasional wrap-prone bases.
    for (int n = 0; n < 150; n++) begin
      logic [AW-1:0] b;
      b = $urandom;
      if ($urandom_range(0, 3) == 0) b = 32'hFFFF_0000 | 32'($urandom_range(0, 16'hFFFF));
      if ($urandom_range(0, 7) == 0) b = 32'($urandom_range(0, 16'hFFFF));
      issue(b, 16'($urandom), 2'($urandom));
    end
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
